// File: rtl/boot_copier.sv
// boot_copier: boot-time bus initiator that shadows a block of 32-bit words
// from the instruction ROM slave into a writable memory slave. The core is
// held off through hold_o while the copy runs.
// Each word takes one READ cycle (ROM address presented, data captured) and
// one WRITE cycle (destination write strobe).
// Optional feature: define BOOT_COPIER_CHECKSUM_EN to add csum_o, which is
// the running 32-bit sum of every word written.
module boot_copier #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              hold_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [31:0]       rd_data_i,
   output logic              wr_we_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic [3:0]        wr_sel_o
`ifdef BOOT_COPIER_CHECKSUM_EN
   ,
   output logic [31:0]       csum_o
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       buf_q, buf_d;
   logic              start_acc;

   logic              busy_q;
   logic              done_q;
   logic              wr_we_q;
   logic [3:0]        wr_sel_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [31:0]       wr_data_q;

   // Next-state and datapath next values; a start is only heard in IDLE.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      start_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               if (len_i != '0) begin
                  src_d   = src_addr_i & ALIGN_MASK;
                  dst_d   = dst_addr_i & ALIGN_MASK;
                  cnt_d   = len_i;
                  state_d = READ;
               end else begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            buf_d   = rd_data_i;
            state_d = WRITE;
         end
         WRITE: begin
            src_d   = src_q + WORD_STEP;
            dst_d   = dst_q + WORD_STEP;
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? DONE : READ;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and working registers (source/destination pointers, count, buffer).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Registered bus outputs, decoded from the upcoming state so they are
   // glitch-free and valid for the whole cycle; addresses/data hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_we_q   <= 1'b0;
         wr_sel_q  <= 4'h0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         busy_q   <= (state_d != IDLE);
         done_q   <= (state_d == DONE);
         wr_we_q  <= (state_d == WRITE);
         wr_sel_q <= (state_d == WRITE) ? 4'hF : 4'h0;
         if (state_d == READ) begin
            rd_addr_q <= src_d;
         end
         if (state_d == WRITE) begin
            wr_addr_q <= dst_d;
            wr_data_q <= buf_d;
         end
      end
   end

   assign busy_o    = busy_q;
   assign hold_o    = busy_q;
   assign done_o    = done_q;
   assign rd_addr_o = rd_addr_q;
   assign wr_we_o   = wr_we_q;
   assign wr_sel_o  = wr_sel_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;

`ifdef BOOT_COPIER_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;

   // Checksum next value: restart on any accepted start, accumulate per write.
   always_comb begin
      csum_d = csum_q;
      if (start_acc) begin
         csum_d = '0;
      end else if (state_q == WRITE) begin
         csum_d = csum_q + buf_q;
      end
   end

   // Checksum register; holds its final value from DONE until the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign csum_o = csum_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_boot_copier.sv
// Testbench for boot_copier: ROM model plus a write scoreboard.
module tb_boot_copier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        busy, done, hold;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        wr_we;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_sel;
`ifdef BOOT_COPIER_CHECKSUM_EN
   logic [31:0] csum;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          wr_cnt = 0;
   logic [31:0] rom [0:15];

   assign rd_data = rom[rd_addr[5:2]];

   boot_copier #(.ADDR_W(32), .LEN_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .src_addr_i (src_addr),
      .dst_addr_i (dst_addr),
      .len_i      (len),
      .busy_o     (busy),
      .done_o     (done),
      .hold_o     (hold),
      .rd_addr_o  (rd_addr),
      .rd_data_i  (rd_data),
      .wr_we_o    (wr_we),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data),
      .wr_sel_o   (wr_sel)
`ifdef BOOT_COPIER_CHECKSUM_EN
      ,
      .csum_o     (csum)
`endif
   );

   always #5 clk = ~clk;

   // Write monitor: every write strobe must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && wr_we) begin
         wr_t e;
         total++;
         wr_cnt++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write addr=%h data=%h", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if (wr_addr !== e.addr || wr_data !== e.data || wr_sel !== 4'hF) begin
               bad++;
               $display("FAIL write_beat got addr=%h data=%h sel=%h want addr=%h data=%h sel=f",
                        wr_addr, wr_data, wr_sel, e.addr, e.data);
            end
         end
      end else if (!rst && wr_sel !== 4'h0) begin
         total++;
         bad++;
         $display("FAIL idle_sel got=%h want=0", wr_sel);
      end
   end

   task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      logic [31:0] sa, da;
      sa = s & 32'hFFFF_FFFC;
      da = d & 32'hFFFF_FFFC;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({da, rom[sa[5:2]]});
         sa = sa + 32'd4;
         da = da + 32'd4;
      end
   endtask

   // Drives a one-cycle start; returns #1 after the accepting edge (cycle 1).
   task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      @(posedge clk);
      #1;
      src_addr = s;
      dst_addr = d;
      len      = n;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string name);
      logic [135:0] v;
      v = {busy, done, hold, rd_addr, wr_we, wr_addr, wr_data, wr_sel};
`ifdef BOOT_COPIER_CHECKSUM_EN
      if (csum !== 32'h0) v[0] = 1'b1;
`endif
      total++;
      if (v !== '0) begin
         bad++;
         $display("FAIL %s outputs=%h want=0", name, v);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) next_cycle();
      check_outputs_zero("reset_state");
      rst = 1'b0;
      // Abort a copy in its second WRITE; outputs must clear asynchronously.
      push_copy(32'h0, 32'h100, 4);
      do_start(32'h0, 32'h100, 16'd4);
      repeat (3) next_cycle();
      rst = 1'b1;
      #1;
      check_outputs_zero("async_reset_midcopy");
      exp_q.delete();
      next_cycle();
      rst = 1'b0;
      begin
         int w0;
         w0 = wr_cnt;
         for (int c = 0; c < 10; c++) begin
            next_cycle();
            total++;
            if (wr_we !== 1'b0 || busy !== 1'b0) begin
               bad++;
               $display("FAIL idle_after_reset c=%0d we=%b busy=%b want 0 0", c, wr_we, busy);
            end
         end
         total++;
         if (wr_cnt !== w0) begin
            bad++;
            $display("FAIL idle_write_count got=%0d want=%0d", wr_cnt, w0);
         end
      end
   endtask

   task automatic test_basic_copy;
      push_copy(32'h0, 32'h1000_0000, 4);
      do_start(32'h0, 32'h1000_0000, 16'd4);
      for (int c = 1; c <= 11; c++) begin
         if (c > 1) next_cycle();
         total++;
         if (busy !== (c <= 9) || hold !== (c <= 9) || done !== (c == 9)) begin
            bad++;
            $display("FAIL basic_ctrl c=%0d busy=%b hold=%b done=%b want %b %b %b",
                     c, busy, hold, done, c <= 9, c <= 9, c == 9);
         end
         if (c == 1 || c == 3 || c == 5 || c == 7) begin
            total++;
            if (rd_addr !== 32'((c - 1) * 2)) begin
               bad++;
               $display("FAIL basic_rd_addr c=%0d got=%h want=%h", c, rd_addr, (c - 1) * 2);
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL basic_pending got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_zero_length;
      logic [31:0] ra;
      int          w0;
      ra = rd_addr;
      w0 = wr_cnt;
      do_start(32'h40, 32'h80, 16'd0);
      total++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL zero_len_c1 done=%b busy=%b want 1 1", done, busy);
      end
      next_cycle();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_len_c2 done=%b busy=%b want 0 0", done, busy);
      end
      next_cycle();
      total++;
      if (rd_addr !== ra || wr_cnt !== w0) begin
         bad++;
         $display("FAIL zero_len_traffic rd_addr=%h writes=%0d want %h %0d", rd_addr, wr_cnt, ra, w0);
      end
   endtask

   task automatic test_misaligned_wrap;
      push_copy(32'h0000_0003, 32'hFFFF_FFFC, 2);
      do_start(32'h0000_0003, 32'hFFFF_FFFC, 16'd2);
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) next_cycle();
         if (c == 1 || c == 3) begin
            total++;
            if (rd_addr !== ((c == 1) ? 32'h0 : 32'h4)) begin
               bad++;
               $display("FAIL wrap_rd_addr c=%0d got=%h", c, rd_addr);
            end
         end
         if (c == 5) begin
            total++;
            if (done !== 1'b1) begin
               bad++;
               $display("FAIL wrap_done got=%b want=1", done);
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL wrap_pending got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back;
      // Start pulsed mid-copy with other arguments must be ignored.
      push_copy(32'h10, 32'h2000, 3);
      do_start(32'h10, 32'h2000, 16'd3);
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) next_cycle();
         if (c == 3) begin
            src_addr = 32'h30;
            dst_addr = 32'h9000;
            len      = 16'd5;
            start    = 1'b1;
         end
         if (c == 4) start = 1'b0;
         total++;
         if (done !== (c == 7) || busy !== (c <= 7)) begin
            bad++;
            $display("FAIL abuse_ctrl c=%0d done=%b busy=%b want %b %b", c, done, busy, c == 7, c <= 7);
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL abuse_pending got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_reset_in_write;
      int w0;
      push_copy(32'h0, 32'h3000, 4);
      do_start(32'h0, 32'h3000, 16'd4);
      repeat (5) next_cycle();
      // Cycle 6 is the third WRITE.
      rst = 1'b1;
      #1;
      check_outputs_zero("reset_3rd_write");
      total++;
      if (exp_q.size() != 2) begin
         bad++;
         $display("FAIL reset_write_left got=%0d want=2", exp_q.size());
      end
      exp_q.delete();
      w0 = wr_cnt;
      next_cycle();
      rst = 1'b0;
      repeat (10) next_cycle();
      total++;
      if (wr_cnt !== w0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_write_after writes=%0d busy=%b want %0d 0", wr_cnt, busy, w0);
      end
   endtask

`ifdef BOOT_COPIER_CHECKSUM_EN
   task automatic test_checksum;
      push_copy(32'h20, 32'h4000, 3);
      do_start(32'h20, 32'h4000, 16'd3);
      for (int c = 2; c <= 7; c++) next_cycle();
      total++;
      if (done !== 1'b1 || csum !== 32'h0000_0002) begin
         bad++;
         $display("FAIL checksum done=%b csum=%h want 1 00000002", done, csum);
      end
      repeat (2) next_cycle();
      total++;
      if (csum !== 32'h0000_0002) begin
         bad++;
         $display("FAIL checksum_hold got=%h want=00000002", csum);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 32'hA500_0000 | 32'(i);
      rom[0]  = 32'h1111_1111;
      rom[1]  = 32'h2222_2222;
      rom[2]  = 32'h3333_3333;
      rom[3]  = 32'h4444_4444;
      rom[4]  = 32'h5555_5555;
      rom[5]  = 32'h6666_6666;
      rom[6]  = 32'h7777_7777;
      rom[8]  = 32'hFFFF_FFFF;
      rom[9]  = 32'h0000_0002;
      rom[10] = 32'h0000_0001;
      test_reset();
      test_basic_copy();
      test_zero_length();
      test_misaligned_wrap();
      test_back_to_back();
      test_reset_in_write();
`ifdef BOOT_COPIER_CHECKSUM_EN
      test_checksum();
`endif
      repeat (2) next_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
